vga_sync_counter: RTL and testbench
===================================

Name: vga_sync_counter

Overview:
- Generates 640x480@60 Hz VGA timing: horizontal/vertical pixel position counters, active-low sync pulses and a visible-area flag.
- It is the source of the position inputs consumed by the rectangle/shape draw blocks, which compare position against limits and return RGB.
- Position numbering includes the sync and back porch, so the first visible pixel is (144,35) and the last is (783,514).
- Runs from the 100 MHz system clock; an internal enable divider produces the 25 MHz pixel rate.

Parameters:
- CLK_DIV, 4, system clocks per pixel; legal values are 1 or more.
- H_TOTAL, 800, pixel clocks per line.
- H_SYNC, 96, hsync low width in pixels (positions 0..95).
- H_VIS_START, 144, first visible horizontal position.
- H_VIS_END, 783, last visible horizontal position (inclusive).
- V_TOTAL, 525, lines per frame.
- V_SYNC, 2, vsync low width in lines (lines 0..1).
- V_VIS_START, 35, first visible line.
- V_VIS_END, 514, last visible line (inclusive).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; when low, all counters hold.
- pixel_tick  out  1  one-clk pulse marking each pixel advance.
- horizontal_actual_position  out  16  current h position, 0..H_TOTAL-1.
- vertical_actual_position  out  16  current line, 0..V_TOTAL-1.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- video_on  out  1  high inside the visible window.
- frame_start  out  1  one-clk pulse when position wraps to (0,0).

Behaviour:
- Registers:
  - div_cnt counts 0..CLK_DIV-1.
  - h_cnt and v_cnt are 16 bits, zero-extended; upper bits stay 0.
- Reset: on a rising clk with rst=1, div_cnt, h_cnt and v_cnt go to 0, and pixel_tick and frame_start go to 0. Outputs are then hsync=0, vsync=0, video_on=0 (position (0,0) lies inside both sync pulses). rst has priority over en. Reset mid-frame restarts at (0,0) on the next edge with no partial-line completion.
- Divider: when en=1, div_cnt increments and wraps from CLK_DIV-1 to 0. The tick condition is div_cnt==CLK_DIV-1 and en=1. With CLK_DIV=1 the tick condition is true on every enabled cycle.
- pixel_tick is registered: it is high for exactly the one cycle after the tick condition, i.e. the cycle in which the new position first appears.
- Horizontal counter: on the tick condition, h_cnt increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter: v_cnt increments only on the tick where h_cnt wraps; at V_TOTAL-1 it wraps to 0. A simultaneous h and v wrap sends (799,524) to (0,0) in a single step.
- en=0 freezes div_cnt, h_cnt and v_cnt and forces pixel_tick=0 and frame_start=0. Counting resumes seamlessly when en returns to 1.
- Combinational decode from the registered counters (zero latency versus the position outputs):
  - hsync = !(h_cnt < H_SYNC)
  - vsync = !(v_cnt < V_SYNC)
  - video_on = (h_cnt >= H_VIS_START && h_cnt <= H_VIS_END && v_cnt >= V_VIS_START && v_cnt <= V_VIS_END)
- Because all three are decoded from the same registers as the positions, they are cycle-aligned with the position outputs. The downstream draw block adds its own 1-cycle RGB register; compensating for that is the top level's job, not this block's.
- frame_start is registered and high for one clk coincident with the first cycle at (0,0) after a wrap. It is not asserted on reset exit.
- Timing totals: a line is H_TOTAL*CLK_DIV = 3200 clks; a frame is 800*525*4 = 1,680,000 clks.

Decomposition:
- Package vga_timing_pkg:
  - the 640x480 constants above, used as parameter defaults;
  - a 16-bit position width constant;
  - shared with the draw blocks so visible-window limits live in one place.
- Sub-module pixel_tick_gen:
  - holds div_cnt and the tick logic;
  - ports clk, rst, en and tick;
  - reused by other blocks that need the 25 MHz enable.
- The counters and sync decode stay in the top module.

Test Plan:
- Reset and start: hold rst for 3 clks, then release with en=1. Required: positions 0/0, hsync=0, vsync=0, video_on=0. The first pixel_tick comes 4 clks after release, showing h=1; frame_start is never asserted.
- hsync timing: over one line, hsync is low for exactly 96 pixels (384 clks) and the hsync falling-edge period is 3200 clks. video_on is first high at h=144,v=35 and low again at h=784,v=35.
- Visible window bounds: (783,514) gives video_on=1; (784,514) gives 0; (144,515) gives 0; (143,35) gives 0.
- Frame wrap: from (799,524) the next tick gives (0,0) with frame_start=1 for exactly 1 clk. The frame_start period is 1,680,000 clks, and vsync is low for 2 lines (6400 clks).
- Enable freeze: deassert en for 10 clks at h=500,v=100. Required: position and div_cnt hold, no pixel_tick. After en=1, counting resumes from h=500 with the same remaining divider phase.
- Reset mid-operation: assert rst for 1 clk at (412,300). Required: (0,0) on the next edge, hsync=0, no frame_start pulse. With CLK_DIV=1, a tick occurs on every clk.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz VGA timing constants and helpers, shared by the sync counter
// and the downstream draw blocks so visible-window limits live in one place.
package vga_timing_pkg;

  localparam int POS_W = 16;

  localparam int CLK_DIV_DEF     = 4;
  localparam int H_TOTAL_DEF     = 800;
  localparam int H_SYNC_DEF      = 96;
  localparam int H_VIS_START_DEF = 144;
  localparam int H_VIS_END_DEF   = 783;
  localparam int V_TOTAL_DEF     = 525;
  localparam int V_SYNC_DEF      = 2;
  localparam int V_VIS_START_DEF = 35;
  localparam int V_VIS_END_DEF   = 514;

  typedef logic [POS_W-1:0] pos_t;

  // Inclusive range test used for visible-window and shape limit compares.
  function automatic logic in_window(input pos_t pos, input pos_t lo, input pos_t hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_counter_if.sv
// Position/sync bundle between the VGA timing source (master) and consumers (slave).
interface vga_sync_counter_if;
  import vga_timing_pkg::*;

  logic en;
  logic pixel_tick;
  pos_t horizontal_actual_position;
  pos_t vertical_actual_position;
  logic hsync;
  logic vsync;
  logic video_on;
  logic frame_start;

  modport master (
    input  en,
    output pixel_tick,
    output horizontal_actual_position,
    output vertical_actual_position,
    output hsync,
    output vsync,
    output video_on,
    output frame_start
  );

  modport slave (
    output en,
    input  pixel_tick,
    input  horizontal_actual_position,
    input  vertical_actual_position,
    input  hsync,
    input  vsync,
    input  video_on,
    input  frame_start
  );

endinterface

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to a pixel-rate enable; tick is combinational
// so users can apply it as a clock enable on the same edge.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (en) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign tick = en && (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_counter.sv
// VGA position counters with sync/visible decode; positions include sync and
// back porch, so the default visible window is (144,35)..(783,514).
module vga_sync_counter
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_VIS_START = H_VIS_START_DEF,
  parameter int H_VIS_END   = H_VIS_END_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_VIS_START = V_VIS_START_DEF,
  parameter int V_VIS_END   = V_VIS_END_DEF
) (
  input  logic               clk,
  input  logic               rst,
  vga_sync_counter_if.master bus
);

  localparam pos_t H_LAST = pos_t'(H_TOTAL - 1);
  localparam pos_t V_LAST = pos_t'(V_TOTAL - 1);

  logic tick;
  pos_t h_cnt;
  pos_t v_cnt;
  logic pixel_tick_q;
  logic frame_start_q;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .tick (tick)
  );

  // frame_start is set only by a counted wrap, never by reset exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      pixel_tick_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pixel_tick_q  <= tick;
      frame_start_q <= 1'b0;
      if (tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          if (v_cnt == V_LAST) begin
            v_cnt         <= '0;
            frame_start_q <= 1'b1;
          end else begin
            v_cnt <= v_cnt + 1'b1;
          end
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  // Decode straight off the counter registers so it aligns with the positions.
  assign bus.horizontal_actual_position = h_cnt;
  assign bus.vertical_actual_position   = v_cnt;
  assign bus.pixel_tick                 = pixel_tick_q;
  assign bus.frame_start                = frame_start_q;
  assign bus.hsync    = !(h_cnt < pos_t'(H_SYNC));
  assign bus.vsync    = !(v_cnt < pos_t'(V_SYNC));
  assign bus.video_on = in_window(h_cnt, pos_t'(H_VIS_START), pos_t'(H_VIS_END)) &&
                        in_window(v_cnt, pos_t'(V_VIS_START), pos_t'(V_VIS_END));

endmodule

// File: tb/tb_vga_sync_counter.sv
// Bench for vga_sync_counter: default 640x480 timing plus two shrunken
// geometries (one with CLK_DIV=1) so whole frames fit in a short run.
module tb_vga_sync_counter;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // Reference state: enabled, non-reset edges since the last reset.
  int n        = 0;
  bit last_adv = 0;
  int cyc      = 0;

  bit meas     = 0;
  int hs_fall_a, vs_fall_b, fs_last_b;
  logic prev_hs_a, prev_vs_b;

  vga_sync_counter_if if_a ();
  vga_sync_counter_if if_b ();
  vga_sync_counter_if if_c ();

  vga_sync_counter dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  vga_sync_counter #(
    .CLK_DIV (3), .H_TOTAL (16), .H_SYNC (3), .H_VIS_START (5), .H_VIS_END (12),
    .V_TOTAL (10), .V_SYNC (2), .V_VIS_START (3), .V_VIS_END (7)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  vga_sync_counter #(
    .CLK_DIV (1), .H_TOTAL (12), .H_SYNC (2), .H_VIS_START (4), .H_VIS_END (9),
    .V_TOTAL (6), .V_SYNC (1), .V_VIS_START (2), .V_VIS_END (4)
  ) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected outputs derived from the number of advanced pixels n/d.
  task automatic check_dut(input string nm, input int d, input int ht, input int hs,
                           input int hvs, input int hve, input int vt, input int vs,
                           input int vvs, input int vve, input logic [15:0] gh,
                           input logic [15:0] gv, input logic gt, input logic ghs,
                           input logic gvs, input logic gvo, input logic gfs);
    int p, h, v;
    bit et, ef, evo;
    p   = n / d;
    h   = p % ht;
    v   = (p / ht) % vt;
    et  = last_adv && (n % d == 0);
    ef  = et && (p % (ht * vt) == 0);
    evo = (h >= hvs) && (h <= hve) && (v >= vvs) && (v <= vve);
    check({nm, ".h"}, gh, h);
    check({nm, ".v"}, gv, v);
    check({nm, ".pixel_tick"}, gt, et);
    check({nm, ".hsync"}, ghs, (h >= hs));
    check({nm, ".vsync"}, gvs, (v >= vs));
    check({nm, ".video_on"}, gvo, evo);
    check({nm, ".frame_start"}, gfs, ef);
  endtask

  task automatic step(input logic r, input logic e);
    @(negedge clk);
    rst     = r;
    if_a.en = e;
    if_b.en = e;
    if_c.en = e;
    @(posedge clk);
    cyc++;
    if (r) begin
      n = 0;
      last_adv = 0;
    end else if (e) begin
      n++;
      last_adv = 1;
    end else begin
      last_adv = 0;
    end
    #1;
    check_dut("a", 4, 800, 96, 144, 783, 525, 2, 35, 514,
              if_a.horizontal_actual_position, if_a.vertical_actual_position,
              if_a.pixel_tick, if_a.hsync, if_a.vsync, if_a.video_on, if_a.frame_start);
    check_dut("b", 3, 16, 3, 5, 12, 10, 2, 3, 7,
              if_b.horizontal_actual_position, if_b.vertical_actual_position,
              if_b.pixel_tick, if_b.hsync, if_b.vsync, if_b.video_on, if_b.frame_start);
    check_dut("c", 1, 12, 2, 4, 9, 6, 1, 2, 4,
              if_c.horizontal_actual_position, if_c.vertical_actual_position,
              if_c.pixel_tick, if_c.hsync, if_c.vsync, if_c.video_on, if_c.frame_start);
    if (meas) begin
      if (prev_hs_a && !if_a.hsync) begin
        if (hs_fall_a >= 0) check("a.hsync_period_clks", cyc - hs_fall_a, 3200);
        hs_fall_a = cyc;
      end
      if (!prev_hs_a && if_a.hsync && hs_fall_a >= 0)
        check("a.hsync_low_clks", cyc - hs_fall_a, 384);
      if (prev_vs_b && !if_b.vsync) begin
        if (vs_fall_b >= 0) check("b.vsync_period_clks", cyc - vs_fall_b, 480);
        vs_fall_b = cyc;
      end
      if (!prev_vs_b && if_b.vsync && vs_fall_b >= 0)
        check("b.vsync_low_clks", cyc - vs_fall_b, 96);
      if (if_b.frame_start) begin
        if (fs_last_b >= 0) check("b.frame_start_period", cyc - fs_last_b, 480);
        fs_last_b = cyc;
      end
    end
    prev_hs_a = if_a.hsync;
    prev_vs_b = if_b.vsync;
  endtask

  initial begin
    int cnt;
    bit found;
    rst     = 1'b1;
    if_a.en = 1'b1;
    if_b.en = 1'b1;
    if_c.en = 1'b1;
    prev_hs_a = 1'b0;
    prev_vs_b = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    cnt = 0;
    found = 0;
    while (!found && cnt < 10) begin
      step(1'b0, 1'b1);
      cnt++;
      if (if_a.pixel_tick) found = 1;
    end
    check("a.first_tick_clks", cnt, 4);
    check("a.first_tick_h", if_a.horizontal_actual_position, 1);

    hs_fall_a = -1;
    vs_fall_b = -1;
    fs_last_b = -1;
    meas = 1;
    for (int i = 0; i < 7000; i++) step(1'b0, 1'b1);
    meas = 0;

    // Freeze mid divider phase at h=500.
    found = 0;
    for (int i = 0; i < 4000 && !found; i++) begin
      step(1'b0, 1'b1);
      if (((n / 4) % 800 == 500) && (n % 4 == 2)) found = 1;
    end
    check("a.reach_h500", found, 1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    check("a.freeze_h", if_a.horizontal_actual_position, 500);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);

    // One-clock reset mid-line at h=412.
    found = 0;
    for (int i = 0; i < 4000 && !found; i++) begin
      step(1'b0, 1'b1);
      if ((n / 4) % 800 == 412) found = 1;
    end
    check("a.reach_h412", found, 1);
    step(1'b1, 1'b1);
    check("a.rst_mid_h", if_a.horizontal_actual_position, 0);
    check("a.rst_mid_hsync", if_a.hsync, 0);
    check("a.rst_mid_frame_start", if_a.frame_start, 0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

    for (int i = 0; i < 8000; i++)
      step(($urandom % 700) == 0, ($urandom % 6) != 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
